matmul_addr_gen: RTL and testbench
==================================

# matmul_addr_gen

Parametrised address sequencer for the matrix-multiply datapath. It replaces the fixed 8-bit three-address register with a generator for C = A·B, where A is M×K and B is K×N. Each step emits one A address and NB B addresses, so NB output columns accumulate in parallel. It sits between the control FSM and the A/B operand memories and drives the MAC array's accumulate-boundary flag.

## Interface
Parameters:
- M, 4, rows of A / C
- K, 4, inner dimension
- N, 4, columns of B / C; N % NB == 0 required
- NB, 2, B address channels (parallel columns)
- AW, 8, address width; M·K ≤ 2^AW and K·N ≤ 2^AW required

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a sequence when idle
- Load  in  1  advance enable; 0 holds current addresses
- b_colmajor  in  1  B storage mode, sampled at start: 0 row-major, 1 column-major
- addrA  out  AW  A address
- addrB  out  NB·AW  B addresses, channel p at bits [p·AW +: AW]
- valid  out  1  addresses are meaningful
- k_last  out  1  current step is k = K−1 (accumulator close)
- done  out  1  one-cycle pulse after the final step
- busy  out  1  high from start acceptance until done

## Operation
- Indices: i (row, 0..M−1), j (column group, 0..N/NB−1), k (0..K−1). Order is k innermost, then j, then i.
- Column of channel p: c = j·NB + p.
- addrA = i·K + k.
- addrB[p] = k·N + c (row-major) or c·K + k (column-major).
- No multipliers. Keep incremental base registers:
  - A base advances by K per row.
  - B: row-major step +N per k, +NB per group; column-major step +1 per k, +NB·K per group.
- FSM states:
  - IDLE: outputs zero; start → RUN with i=j=k=0 and mode latched.
  - RUN: valid=1. Load=1 advances one step per cycle; Load=0 holds all outputs.
  - RUN → DONE: Load=1 on the last step (i=M−1, j=N/NB−1, k=K−1).
  - DONE: done=1 and valid=0 for one cycle → IDLE.
- start is ignored outside IDLE. b_colmajor is ignored except at acceptance.
- Reset at any time forces IDLE and zeros every output and index in the same cycle.
- Total Load-cycles per sequence: M·(N/NB)·K.

## Timing
- All outputs are registered. Reset values: addrA=0, addrB=0, valid=0, k_last=0, done=0, busy=0.
- start sampled high at edge t gives valid=1 with first addresses (addrA=0, addrB[p]=first column address) after edge t, i.e. during cycle t+1. busy rises at the same time.
- Advance latency is 1 cycle: Load high at edge t shows the next step's addresses after t.
- k_last is combinationally aligned with its addresses (registered together).
- After the final Load edge: done=1, busy=1, valid=0 for one cycle. busy falls with done.
- The earliest next start is accepted in the first cycle back in IDLE.
- start coinciding with done is ignored.

## Structure
- matmul_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - localparam helpers: NG = N/NB, step count
  - parameter-legality checks, as an elaboration-time assertion macro/function
- One sub-module, matmul_idx_counter: a three-level nested wrap counter (k, j, i) with enable. It outputs the indices plus wrap flags (k_wrap, j_wrap, last). The top module owns the address base registers and the FSM.

## Test plan
- Reset mid-RUN: assert reset while busy at step 5 → all outputs 0 immediately. A new start then begins again at addrA=0.
- Defaults, row-major, Load held high after start:
  - steps 0–3: addrA 0,1,2,3; addrB {0,1},{4,5},{8,9},{12,13}; k_last high on step 3
  - step 4: addrA 0, addrB {2,3}
  - step 8: addrA 4, addrB {0,1}
  - done pulses once after 32 Load cycles
- Column-major (b_colmajor=1 at start):
  - steps 0–3: addrB {0,4},{1,5},{2,6},{3,7}
  - step 4: addrB {8,12}
  - last step: addrA 15, addrB {11,15}
- Load gaps: drop Load for 3 cycles at step 10 → outputs frozen and valid stays 1; resume → step 11 follows with no skip or duplicate. done arrives 3 cycles later than the gap-free run.
- start while busy and start in the done cycle → both ignored, sequence unaffected. Changing b_colmajor mid-run has no effect.
- Parameter sweep M=3, K=5, N=6, NB=3, AW=8:
  - step 5: addrA 0, addrB {3,4,5}
  - final step: addrA 14, addrB {27,28,29}
  - 30 steps total

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and elaboration-time helpers for the matrix-multiply address generator.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_groups(input int n, input int nb);
    return n / nb;
  endfunction

  function automatic int step_count(input int m, input int k, input int n, input int nb);
    return m * num_groups(n, nb) * k;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Every address of A and B must be representable in AW bits.
  function automatic bit params_legal(input int m, input int k, input int n, input int nb,
                                      input int aw);
    longint cap;
    cap = longint'(1) << aw;
    return (m > 0) && (k > 0) && (n > 0) && (nb > 0) && (aw > 0) && (n % nb == 0) &&
           (longint'(m) * longint'(k) <= cap) && (longint'(k) * longint'(n) <= cap);
  endfunction

endpackage

// File: rtl/matmul_idx_counter.sv
// Three-level nested wrap counter: k innermost, then column group j, then row i.
module matmul_idx_counter
  import matmul_pkg::*;
#(
  parameter int KC = 4,
  parameter int JC = 2,
  parameter int IC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  output logic [idx_width(KC)-1:0] k_idx,
  output logic [idx_width(JC)-1:0] j_idx,
  output logic [idx_width(IC)-1:0] i_idx,
  output logic                     k_wrap,
  output logic                     j_wrap,
  output logic                     last
);

  localparam int KW = idx_width(KC);
  localparam int JW = idx_width(JC);
  localparam int IW = idx_width(IC);
  localparam logic [KW-1:0] K_MAX = KW'(KC - 1);
  localparam logic [JW-1:0] J_MAX = JW'(JC - 1);
  localparam logic [IW-1:0] I_MAX = IW'(IC - 1);

  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic [IW-1:0] i_q, i_d;

  assign k_wrap = (k_q == K_MAX);
  assign j_wrap = (j_q == J_MAX);
  assign last   = k_wrap && j_wrap && (i_q == I_MAX);

  always_comb begin
    k_d = k_q;
    j_d = j_q;
    i_d = i_q;
    if (clr) begin
      k_d = '0;
      j_d = '0;
      i_d = '0;
    end else if (en) begin
      if (!k_wrap) begin
        k_d = k_q + KW'(1);
      end else begin
        k_d = '0;
        if (!j_wrap) begin
          j_d = j_q + JW'(1);
        end else begin
          j_d = '0;
          i_d = last ? '0 : i_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else begin
      k_q <= k_d;
      j_q <= j_d;
      i_q <= i_d;
    end
  end

  assign k_idx = k_q;
  assign j_idx = j_q;
  assign i_idx = i_q;

endmodule

// File: rtl/matmul_addr_gen.sv
// Address sequencer for C = A*B: one A address and NB parallel B addresses per step,
// built from incremental base registers so no multipliers are needed at run time.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int N  = 4,
  parameter int NB = 2,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Load,
  input  logic             b_colmajor,
  output logic [AW-1:0]    addrA,
  output logic [NB*AW-1:0] addrB,
  output logic             valid,
  output logic             k_last,
  output logic             done,
  output logic             busy
);

  localparam int NG = num_groups(N, NB);
  localparam int KW = idx_width(K);
  localparam int JW = idx_width(NG);
  localparam int IW = idx_width(M);
  localparam logic [AW-1:0] ONE_AW  = AW'(1);
  localparam logic [AW-1:0] K_STEP  = AW'(K);
  localparam logic [AW-1:0] N_STEP  = AW'(N);
  localparam logic [AW-1:0] GRP_ROW = AW'(NB);
  localparam logic [AW-1:0] GRP_COL = AW'(NB * K);
  localparam logic [KW-1:0] K_PEN   = KW'(K - 2);
  localparam logic          K_ONE   = (K == 1);

  if (!params_legal(M, K, N, NB, AW)) begin : g_bad_params
    $error("matmul_addr_gen: illegal parameter set (N %% NB, M*K, K*N vs 2**AW)");
  end

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] a_base_q, a_base_d;
  logic [AW-1:0] b_grp_q, b_grp_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic          k_last_q, k_last_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          load_first, step, clear_out, advance;

  logic [KW-1:0] k_idx;
  logic [JW-1:0] j_idx;
  logic [IW-1:0] i_idx;
  logic          k_wrap, j_wrap, last;
  logic          unused_idx;

  assign advance    = (state_q == RUN) && Load;
  assign unused_idx = ^{j_idx, i_idx};

  matmul_idx_counter #(
    .KC(K),
    .JC(NG),
    .IC(M)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .clr   (load_first),
    .en    (advance),
    .k_idx (k_idx),
    .j_idx (j_idx),
    .i_idx (i_idx),
    .k_wrap(k_wrap),
    .j_wrap(j_wrap),
    .last  (last)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    a_base_d   = a_base_q;
    b_grp_d    = b_grp_q;
    addr_a_d   = addr_a_q;
    k_last_d   = k_last_q;
    load_first = 1'b0;
    step       = 1'b0;
    clear_out  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          mode_d     = b_colmajor;
          load_first = 1'b1;
        end
      end
      RUN: begin
        if (Load) begin
          if (last) begin
            state_d   = DONE;
            clear_out = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        clear_out = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        clear_out = 1'b1;
      end
    endcase

    // A row base moves only when the whole row of column groups has been swept.
    if (load_first) begin
      a_base_d = '0;
      b_grp_d  = '0;
      addr_a_d = '0;
      k_last_d = K_ONE;
    end else if (step) begin
      if (k_wrap) begin
        k_last_d = K_ONE;
        if (j_wrap) begin
          a_base_d = a_base_q + K_STEP;
          addr_a_d = a_base_q + K_STEP;
          b_grp_d  = '0;
        end else begin
          addr_a_d = a_base_q;
          b_grp_d  = b_grp_q + (mode_q ? GRP_COL : GRP_ROW);
        end
      end else begin
        addr_a_d = addr_a_q + ONE_AW;
        k_last_d = (k_idx == K_PEN);
      end
    end else if (clear_out) begin
      addr_a_d = '0;
      k_last_d = 1'b0;
    end

    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      a_base_q <= '0;
      b_grp_q  <= '0;
      addr_a_q <= '0;
      k_last_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_base_q <= a_base_d;
      b_grp_q  <= b_grp_d;
      addr_a_q <= addr_a_d;
      k_last_q <= k_last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Channel p sits a fixed offset from the group base: +p row-major, +p*K column-major.
  for (genvar gi = 0; gi < NB; gi++) begin : g_chan
    localparam logic [AW-1:0] OFF_ROW = AW'(gi);
    localparam logic [AW-1:0] OFF_COL = AW'(gi * K);
    logic [AW-1:0] addr_b_q, addr_b_d;

    always_comb begin
      addr_b_d = addr_b_q;
      if (load_first) begin
        addr_b_d = b_colmajor ? OFF_COL : OFF_ROW;
      end else if (step) begin
        if (k_wrap) begin
          addr_b_d = b_grp_d + (mode_q ? OFF_COL : OFF_ROW);
        end else begin
          addr_b_d = addr_b_q + (mode_q ? ONE_AW : N_STEP);
        end
      end else if (clear_out) begin
        addr_b_d = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        addr_b_q <= '0;
      end else begin
        addr_b_q <= addr_b_d;
      end
    end

    assign addrB[gi*AW +: AW] = addr_b_q;
  end

  assign addrA  = addr_a_q;
  assign valid  = valid_q;
  assign k_last = k_last_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Scoreboard bench: two instances (default 4x4x4/NB=2 and 3x5x6/NB=3), randomized Load gaps,
// stray starts and mode toggles, checked against an index-arithmetic reference model.
module tb_matmul_addr_gen;

  typedef struct packed {
    logic        kl;
    logic [7:0]  a;
    logic [47:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       start_s, load_s, bcol_s;
  wire  [1:0][7:0]  addr_a_s;
  wire  [15:0]      addr_b0;
  wire  [23:0]      addr_b1;
  wire  [1:0]       valid_s, klast_s, done_s, busy_s;

  exp_t q0[$];
  exp_t q1[$];
  int   exp_done[2];
  int   popped[2];
  int   n_cmp  = 0;
  int   n_fail = 0;

  matmul_addr_gen #(.M(4), .K(4), .N(4), .NB(2), .AW(8)) dut0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .Load(load_s[0]), .b_colmajor(bcol_s[0]),
    .addrA(addr_a_s[0]), .addrB(addr_b0), .valid(valid_s[0]), .k_last(klast_s[0]),
    .done(done_s[0]), .busy(busy_s[0])
  );

  matmul_addr_gen #(.M(3), .K(5), .N(6), .NB(3), .AW(8)) dut1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .Load(load_s[1]), .b_colmajor(bcol_s[1]),
    .addrA(addr_a_s[1]), .addrB(addr_b1), .valid(valid_s[1]), .k_last(klast_s[1]),
    .done(done_s[1]), .busy(busy_s[1])
  );

  function automatic int pm(input int id);  return (id != 0) ? 3 : 4; endfunction
  function automatic int pk(input int id);  return (id != 0) ? 5 : 4; endfunction
  function automatic int pn(input int id);  return (id != 0) ? 6 : 4; endfunction
  function automatic int pnb(input int id); return (id != 0) ? 3 : 2; endfunction

  function automatic logic [47:0] get_b(input int id);
    return (id != 0) ? 48'(addr_b1) : 48'(addr_b0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: enumerate (i, j, k) in order and apply the address formulas directly.
  task automatic push_model(input int id, input bit mode);
    int m, k, n, nb;
    m = pm(id); k = pk(id); n = pn(id); nb = pnb(id);
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n / nb; j++) begin
        for (int kk = 0; kk < k; kk++) begin
          exp_t e;
          e    = '0;
          e.a  = 8'(i * k + kk);
          e.kl = (kk == k - 1);
          for (int p = 0; p < nb; p++) begin
            int c;
            c = j * nb + p;
            e.b[p*8 +: 8] = 8'(mode ? (c * k + kk) : (kk * n + c));
          end
          if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
    end
    exp_done[id]++;
  endtask

  task automatic monitor(input int id);
    exp_t e, act;
    int   depth;
    depth = (id != 0) ? q1.size() : q0.size();
    if (valid_s[id]) begin
      if (depth == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL dut%0d_unexpected_valid: got valid=1 addrA=%0d, required no output", id,
                 addr_a_s[id]);
      end else begin
        e        = (id != 0) ? q1[0] : q0[0];
        act      = '0;
        act.a    = addr_a_s[id];
        act.kl   = klast_s[id];
        act.b    = get_b(id);
        check($sformatf("dut%0d_step%0d", id, popped[id]), 64'(act), 64'(e));
        check($sformatf("dut%0d_busy_done_in_run", id), 64'({busy_s[id], done_s[id]}), 64'(2'b10));
        if (load_s[id]) begin
          if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          popped[id]++;
        end
      end
    end
    if (done_s[id]) begin
      check($sformatf("dut%0d_done_event", id),
            64'({valid_s[id], busy_s[id], depth == 0, exp_done[id] > 0}), 64'(4'b0111));
      if (exp_done[id] > 0) exp_done[id]--;
    end
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  task automatic flush(input int id);
    if (id == 0) q0.delete(); else q1.delete();
    exp_done[id] = 0;
    popped[id]   = 0;
  endtask

  // Called mid-cycle with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_seq(input int id, input bit mode, input int lowpct, input bit pokes);
    int lows, n, steps;
    bit seen;
    lows = 0; n = 0; seen = 0;
    steps = pm(id) * (pn(id) / pnb(id)) * pk(id);
    popped[id] = 0;
    push_model(id, mode);
    start_s[id] = 1'b1; bcol_s[id] = mode; load_s[id] = 1'b1;
    @(posedge clk); #1;
    start_s[id] = 1'b0; bcol_s[id] = ~mode;
    while (!seen && n < 4 * steps + 50) begin
      n++;
      load_s[id] = ($urandom_range(99) >= lowpct);
      if (pokes) begin
        start_s[id] = ($urandom_range(7) == 0);
        bcol_s[id]  = 1'($urandom_range(1));
      end
      @(negedge clk);
      if (done_s[id]) begin
        seen = 1'b1;
      end else begin
        if (valid_s[id] && !load_s[id]) lows++;
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL dut%0d_done_timeout: got no done after %0d cycles, required done", id, n);
      start_s[id] = 1'b0; load_s[id] = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      flush(0); flush(1);
      reset = 1'b0;
      @(negedge clk);
      return;
    end
    check($sformatf("dut%0d_done_latency", id), 64'(n), 64'(steps + lows + 1));
    start_s[id] = 1'b1;
    @(posedge clk); #1;
    start_s[id] = 1'b0; load_s[id] = 1'b0;
    @(negedge clk);
    check($sformatf("dut%0d_idle_after_done", id),
          64'({valid_s[id], busy_s[id], done_s[id]}), 64'(0));
    $display("dut%0d sequence mode=%0d lowpct=%0d pokes=%0d: %0d steps, %0d hold cycles, done at cycle %0d",
             id, mode, lowpct, pokes, steps, lows, n);
  endtask

  task automatic reset_mid_run();
    push_model(0, 1'b0);
    popped[0] = 0;
    start_s[0] = 1'b1; bcol_s[0] = 1'b0; load_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_at_step5", 64'({busy_s[0], addr_a_s[0]}), 64'({1'b1, 8'd1}));
    #1;
    reset = 1'b1;
    flush(0);
    #1;
    check("outputs_zero_on_reset",
          64'({addr_a_s[0], addr_b0, valid_s[0], klast_s[0], done_s[0], busy_s[0]}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; load_s[0] = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 64'({valid_s[0], busy_s[0], done_s[0]}), 64'(0));
    $display("dut0 reset asserted at step 5, outputs cleared");
  endtask

  initial begin
    reset   = 1'b1;
    start_s = '0;
    load_s  = '0;
    bcol_s  = '0;
    exp_done = '{0, 0};
    popped   = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check("reset_state_dut0",
          64'({addr_a_s[0], addr_b0, valid_s[0], klast_s[0], done_s[0], busy_s[0]}), 64'(0));
    check("reset_state_dut1",
          64'({addr_a_s[1], addr_b1, valid_s[1], klast_s[1], done_s[1], busy_s[1]}), 64'(0));
    start_s = 2'b11;
    @(posedge clk); #1;
    start_s = '0;
    reset   = 1'b0;
    @(negedge clk);

    run_seq(0, 1'b0, 0, 1'b0);
    run_seq(0, 1'b1, 0, 1'b0);
    run_seq(0, 1'b0, 0, 1'b1);
    for (int r = 0; r < 3; r++) run_seq(0, 1'($urandom_range(1)), 25, 1'b1);
    reset_mid_run();
    run_seq(0, 1'b0, 0, 1'b0);
    run_seq(1, 1'b0, 0, 1'b0);
    run_seq(1, 1'b1, 0, 1'b1);
    run_seq(1, 1'($urandom_range(1)), 30, 1'b1);

    @(negedge clk);
    check("scoreboard_drained",
          64'({16'(q0.size()), 16'(q1.size()), 16'(exp_done[0]), 16'(exp_done[1])}), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
